// File: rtl/recepcion_adc_if.sv
`timescale 1ns/1ps
// Bundle of the ADC serial link and the parallel sample output of recepcion_adc.
// Signals: CS (chip select, active low), DinSerial (ADC data), DoutParalelo,
//          DatoListo (one-cycle strobe) and ErrorTrama (nonzero leading bits).
// master: the receiver drives CS and the sample outputs; slave: the ADC/consumer side.
interface recepcion_adc_if;
    logic        CS;
    logic        DinSerial;
    logic [11:0] DoutParalelo;
    logic        DatoListo;
    logic        ErrorTrama;

    modport master (
        output CS,
        input  DinSerial,
        output DoutParalelo,
        output DatoListo,
        output ErrorTrama
    );

    modport slave (
        input  CS,
        output DinSerial,
        input  DoutParalelo,
        input  DatoListo,
        input  ErrorTrama
    );
endinterface

// File: rtl/recepcion_adc.sv
`timescale 1ns/1ps
// Serial-to-parallel receiver for a 12-bit ADC with a 16-bit frame (4 leading zeros + 12 data bits, MSB first).
// Latency: CS falls at edge k, bits sampled at k+1..k+16, sample and DatoListo published at edge k+17.
// No backpressure: DatoListo is a one-cycle strobe that the consumer must take when it fires.
// Ports: CLK1MHz (system and ADC serial clock), Reset (synchronous, active high),
//        Enable (level; repeats conversions every PERIODO cycles), bus (recepcion_adc_if.master).
module recepcion_adc #(
    parameter int unsigned PERIODO = 20   // frame start to frame start, legal 18..255
) (
    input  logic             CLK1MHz,
    input  logic             Reset,
    input  logic             Enable,
    recepcion_adc_if.master  bus
);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        TRAMA    = 2'd1,
        CARGA    = 2'd2,
        SILENCIO = 2'd3
    } estado_t;

    localparam logic [7:0] PER_FIN = 8'(PERIODO - 1);

    estado_t     state_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  per_cnt_q;
    logic [15:0] sr_q;

    logic [15:0] sr_d;
    logic [7:0]  per_cnt_d;

    // Serial bit enters at the LSB, so after 16 shifts the first bit is at sr[15].
    assign sr_d      = {sr_q[14:0], bus.DinSerial};
    // Saturating so a long idle in REPOSO cannot wrap into a false period match.
    assign per_cnt_d = (per_cnt_q == 8'hFF) ? per_cnt_q : per_cnt_q + 8'd1;

    // Chip select is decoded straight from the state register: low only in TRAMA.
    assign bus.CS = (state_q != TRAMA);

    always_ff @(posedge CLK1MHz) begin
        if (Reset) begin
            state_q          <= REPOSO;
            bit_cnt_q        <= 4'd0;
            per_cnt_q        <= 8'd0;
            sr_q             <= 16'd0;
            bus.DoutParalelo <= 12'h000;
            bus.DatoListo    <= 1'b0;
            bus.ErrorTrama   <= 1'b0;
        end else begin
            bus.DatoListo <= 1'b0;
            per_cnt_q     <= per_cnt_d;

            case (state_q)
                REPOSO: begin
                    if (Enable) begin
                        state_q   <= TRAMA;
                        per_cnt_q <= 8'd0;
                    end
                end

                TRAMA: begin
                    sr_q <= sr_d;
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_q <= 4'd0;
                        state_q   <= CARGA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end

                CARGA: begin
                    // Data bits are published even when the leading nibble is corrupt;
                    // ErrorTrama flags the frame instead of suppressing it.
                    bus.DoutParalelo <= sr_q[11:0];
                    bus.ErrorTrama   <= (sr_q[15:12] != 4'd0);
                    bus.DatoListo    <= 1'b1;
                    state_q          <= SILENCIO;
                end

                SILENCIO: begin
                    // Period counter was cleared on TRAMA entry, so this match lands the
                    // next frame start exactly PERIODO cycles after the previous one.
                    if (per_cnt_q == PER_FIN) begin
                        if (Enable) begin
                            state_q   <= TRAMA;
                            per_cnt_q <= 8'd0;
                        end else begin
                            state_q   <= REPOSO;
                        end
                    end
                end

                default: state_q <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_recepcion_adc.sv
`timescale 1ns/1ps
// Self-checking bench for recepcion_adc: an ADC model serves 16-bit words while CS is low,
// and a frame-level reference (word -> data/error, fixed latencies) checks every publication.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_recepcion_adc;

    localparam int PER = 20;

    logic clk;
    logic Reset;
    logic Enable;

    recepcion_adc_if bus ();

    recepcion_adc #(.PERIODO(PER)) dut (
        .CLK1MHz (clk),
        .Reset   (Reset),
        .Enable  (Enable),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    typedef struct {
        logic [15:0] word;
        int          fall;
    } exp_t;

    logic [15:0] word_q[$];     // words the ADC will serve, in order
    exp_t        exp_q[$];      // completed frames awaiting publication
    int          falls[$];      // cycle of every CS fall
    int          dls[$];        // cycle of every DatoListo
    logic [15:0] last_word = 16'h0000;

    int          cyc = 0;
    bit          frame_active = 0;
    int          idx = 0;
    int          cs_low = 0;
    int          fall_cyc = 0;
    logic [15:0] cur_word = 16'h0000;
    logic        prev_dl = 1'b0;

    // ADC model and monitor.
    initial begin
        exp_t e;
        bus.DinSerial = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (Reset) begin
                if (frame_active) check("rst_cs_high", 32'(bus.CS), 32'd1);
                frame_active = 0;
                exp_q.delete();
                prev_dl   = 1'b0;
                last_word = 16'h0000;
                bus.DinSerial = 1'($urandom);
            end else begin
                if (!bus.CS) begin
                    if (!frame_active) begin
                        frame_active = 1;
                        idx      = 15;
                        cs_low   = 0;
                        fall_cyc = cyc;
                        falls.push_back(cyc);
                        if (word_q.size() != 0) cur_word = word_q.pop_front();
                        else                    cur_word = 16'($urandom);
                    end else begin
                        idx--;
                    end
                    cs_low++;
                    if (idx >= 0) bus.DinSerial = cur_word[idx];
                    else          bus.DinSerial = 1'b0;
                end else begin
                    if (frame_active) begin
                        frame_active = 0;
                        check("cs_low_cycles", 32'(cs_low), 32'd16);
                        e.word = cur_word;
                        e.fall = fall_cyc;
                        exp_q.push_back(e);
                    end
                    bus.DinSerial = 1'($urandom);
                end

                if (bus.DatoListo) begin
                    dls.push_back(cyc);
                    check("dl_one_cycle", 32'(prev_dl), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("dl_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        last_word = e.word;
                        check("dout", 32'(bus.DoutParalelo), 32'(e.word[11:0]));
                        check("error_trama", 32'(bus.ErrorTrama), 32'(e.word[15:12] != 4'd0));
                        check("dl_latency", 32'(cyc - e.fall), 32'd17);
                    end
                end
                prev_dl = bus.DatoListo;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_enable();
        @(negedge clk) Enable = 1'b1;
        @(negedge clk) Enable = 1'b0;
    endtask

    task automatic wait_falls(input int target);
        for (int i = 0; i < 300 && falls.size() < target; i++) @(negedge clk);
        check("cs_fall_timeout", 32'(falls.size() >= target), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf, nd;
        Reset  = 1'b1;
        Enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cs",   32'(bus.CS),           32'd1);
        check("reset_dout", 32'(bus.DoutParalelo), 32'h000);
        check("reset_dl",   32'(bus.DatoListo),    32'd0);
        check("reset_err",  32'(bus.ErrorTrama),   32'd0);
        Reset = 1'b0;
        idle(5);

        // Single frame, clean leading nibble.
        nf = falls.size(); nd = dls.size();
        word_q.push_back(16'h0ABC);
        pulse_enable();
        idle(45);
        check("t1_frames", 32'(falls.size() - nf), 32'd1);
        check("t1_dl",     32'(dls.size() - nd),   32'd1);
        check("t1_dout",   32'(bus.DoutParalelo),  32'hABC);

        // Single frame, corrupt leading nibble.
        nf = falls.size(); nd = dls.size();
        word_q.push_back(16'h8123);
        pulse_enable();
        idle(45);
        check("t2_frames", 32'(falls.size() - nf), 32'd1);
        check("t2_dl",     32'(dls.size() - nd),   32'd1);
        check("t2_err",    32'(bus.ErrorTrama),    32'd1);

        // Back-to-back frames with Enable held.
        nf = falls.size(); nd = dls.size();
        word_q.push_back(16'h0001);
        word_q.push_back(16'h0FFF);
        word_q.push_back(16'h0800);
        @(negedge clk) Enable = 1'b1;
        wait_falls(nf + 3);
        Enable = 1'b0;
        idle(60);
        check("t3_frames", 32'(falls.size() - nf), 32'd3);
        check("t3_dl",     32'(dls.size() - nd),   32'd3);
        if (falls.size() >= nf + 3) begin
            check("t3_cs_gap1", 32'(falls[nf+1] - falls[nf]),   32'(PER));
            check("t3_cs_gap2", 32'(falls[nf+2] - falls[nf+1]), 32'(PER));
        end
        if (dls.size() >= nd + 3) begin
            check("t3_dl_gap1", 32'(dls[nd+1] - dls[nd]),   32'(PER));
            check("t3_dl_gap2", 32'(dls[nd+2] - dls[nd+1]), 32'(PER));
        end

        // Reset at cycle k+8 of a frame.
        nf = falls.size(); nd = dls.size();
        word_q.push_back(16'h0555);
        pulse_enable();
        wait_falls(nf + 1);
        repeat (7) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk) Reset = 1'b0;
        idle(40);
        check("t4_frames", 32'(falls.size() - nf), 32'd1);
        check("t4_no_dl",  32'(dls.size() - nd),   32'd0);
        check("t4_dout",   32'(bus.DoutParalelo),  32'h000);
        check("t4_err",    32'(bus.ErrorTrama),    32'd0);
        word_q.push_back(16'($urandom) & 16'h0FFF);
        pulse_enable();
        idle(40);
        check("t4_clean_dl", 32'(dls.size() - nd), 32'd1);

        // Enable dropped mid-frame: frame completes, no follow-on frame.
        nf = falls.size(); nd = dls.size();
        word_q.push_back(16'h0F0F);
        @(negedge clk) Enable = 1'b1;
        wait_falls(nf + 1);
        repeat (5) @(negedge clk);
        Enable = 1'b0;
        idle(60);
        check("t5_frames", 32'(falls.size() - nf), 32'd1);
        check("t5_dl",     32'(dls.size() - nd),   32'd1);

        // Idle with a noisy data line: outputs must hold the last published sample.
        nd = dls.size();
        idle(60);
        check("t6_dout_hold", 32'(bus.DoutParalelo), 32'(last_word[11:0]));
        check("t6_err_hold",  32'(bus.ErrorTrama),   32'(last_word[15:12] != 4'd0));
        check("t6_no_dl",     32'(dls.size() - nd),  32'd0);

        // Randomized single frames, including random leading nibbles.
        nf = falls.size(); nd = dls.size();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (i % 2 == 0) w[15:12] = 4'd0;
            word_q.push_back(w);
            pulse_enable();
            idle(40 + int'($urandom_range(0, 10)));
        end
        check("t7_frames", 32'(falls.size() - nf), 32'd8);
        check("t7_dl",     32'(dls.size() - nd),   32'd8);

        check("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
